// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX and RX paths: frame geometry, state encoding, parity.
// The UART_TX_ODD_PARITY_EN macro selects odd parity instead of the default even parity.
package uart_pkg;

  localparam int FRAME_BITS            = 11;
  localparam int DATA_BITS             = 8;
  localparam int BIT_COUNTS_9600_50MHZ = 5208;
  localparam logic LINE_IDLE           = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] data);
`ifdef UART_TX_ODD_PARITY_EN
    return ~^data;
`else
    return ^data;
`endif
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time generator: tick is high for one cycle every BIT_COUNTS cycles, restarted by clear.
// Shared between the UART transmit and receive paths.
module uart_baud_tick #(
  parameter int BIT_COUNTS = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (BIT_COUNTS > 1) ? $clog2(BIT_COUNTS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_COUNTS - 1);

  logic [CW-1:0] r_count;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign tick = !clear && (r_count == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_W data bits LSB first, parity, stop; all outputs registered.
// Define UART_TX_ODD_PARITY_EN for odd parity; default build sends even parity.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int BIT_COUNTS = BIT_COUNTS_9600_50MHZ,
  parameter int DATA_W     = DATA_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_start,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              parity_o
);

  localparam int IW = $clog2(DATA_W);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [IW-1:0]     r_bit_idx;
  logic              r_tx;
  logic              r_busy;
  logic              r_done;
  logic              r_parity;
  logic              w_tick;
  logic              w_clear;

  // Holding the counter cleared throughout IDLE restarts the bit time on every acceptance.
  assign w_clear = (r_state == IDLE);

  uart_baud_tick #(
    .BIT_COUNTS(BIT_COUNTS)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(w_clear),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= LINE_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_parity  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_tx   <= LINE_IDLE;
          r_busy <= 1'b0;
          if (tx_start) begin
            r_shift  <= tx_data;
            r_parity <= parity_of(tx_data);
            r_tx     <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= START;
          end
        end
        START: begin
          if (w_tick) begin
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift <= r_shift >> 1;
            if (r_bit_idx == LAST_IDX) begin
              r_tx    <= r_parity;
              r_state <= PARITY;
            end else begin
              r_bit_idx <= r_bit_idx + IW'(1);
              r_tx      <= r_shift[1];
            end
          end
        end
        PARITY: begin
          if (w_tick) begin
            r_tx    <= LINE_IDLE;
            r_state <= STOP;
          end
        end
        STOP: begin
          if (w_tick) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign done     = r_done;
  assign parity_o = r_parity;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame with BIT_COUNTS=8 (88-cycle frames); outputs sampled on negedge.
module tb_uart_tx_frame;

  localparam int BC = 8;
  localparam int FRAME_CYC = 11 * BC;
`ifdef UART_TX_ODD_PARITY_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx, busy, done, parity_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [10:0] f_bits;
  int          f_done_n, f_done_cnt, f_busy_cnt, f_start;
  logic        f_busy_end;
  bit          f_found;

  uart_tx_frame #(.BIT_COUNTS(BC), .DATA_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .tx      (tx),
    .busy    (busy),
    .done    (done),
    .parity_o(parity_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected line pattern, index 0 = start bit; p_even is the hand-computed even parity.
  function automatic logic [10:0] frame_of(input logic [7:0] d, input logic p_even);
    return {1'b1, p_even ^ ODD, d, 1'b0};
  endfunction

  // Called at a negedge with the DUT idle: request one frame.
  task automatic pulse_start(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Waits (bounded) for tx low, then samples each bit mid-bit and tracks done/busy over the frame.
  task automatic get_frame();
    f_found = 0; f_done_n = -1; f_done_cnt = 0; f_busy_cnt = 0; f_bits = 'x; f_busy_end = 'x;
    for (int i = 0; i < 300; i++) begin
      if (tx === 1'b0) begin
        f_found = 1;
        break;
      end
      @(negedge clk);
    end
    if (!f_found) return;
    f_start = cyc;
    for (int n = 0; n <= FRAME_CYC; n++) begin
      if (n > 0) @(negedge clk);
      if (n < FRAME_CYC && (n % BC) == BC / 2) f_bits[n / BC] = tx;
      if (done === 1'b1) begin
        f_done_cnt++;
        if (f_done_n < 0) f_done_n = n;
      end
      if (n < FRAME_CYC && busy === 1'b1) f_busy_cnt++;
      if (n == FRAME_CYC) f_busy_end = busy;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_start = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b want 1", tx); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (parity_o !== 1'b0) begin miscompares++; $display("FAIL reset_parity_o: got %b want 0", parity_o); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic [10:0] exp;
    exp = frame_of(8'h41, 1'b0);
    pulse_start(8'h41);
    get_frame();
    vectors++; if (!f_found) begin miscompares++; $display("FAIL single_found: no start bit within bound"); end
    vectors++; if (f_bits !== exp) begin miscompares++; $display("FAIL single_bits: got %b want %b", f_bits, exp); end
    vectors++; if (f_done_n != FRAME_CYC) begin miscompares++; $display("FAIL single_done_at: got %0d want %0d", f_done_n, FRAME_CYC); end
    vectors++; if (f_done_cnt != 1) begin miscompares++; $display("FAIL single_done_cnt: got %0d want 1", f_done_cnt); end
    vectors++; if (f_busy_cnt != FRAME_CYC) begin miscompares++; $display("FAIL single_busy_cycles: got %0d want %0d", f_busy_cnt, FRAME_CYC); end
    vectors++; if (f_busy_end !== 1'b0) begin miscompares++; $display("FAIL single_busy_end: got %b want 0", f_busy_end); end
    vectors++; if (parity_o !== ODD) begin miscompares++; $display("FAIL single_parity_o: got %b want %b", parity_o, ODD); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_parity();
    pulse_start(8'h07);
    get_frame();
    vectors++; if (f_bits[9] !== (1'b1 ^ ODD)) begin miscompares++; $display("FAIL parity_07_bit: got %b want %b", f_bits[9], 1'b1 ^ ODD); end
    vectors++; if (parity_o !== (1'b1 ^ ODD)) begin miscompares++; $display("FAIL parity_07_o: got %b want %b", parity_o, 1'b1 ^ ODD); end
    vectors++; if (f_bits !== frame_of(8'h07, 1'b1)) begin miscompares++; $display("FAIL parity_07_frame: got %b want %b", f_bits, frame_of(8'h07, 1'b1)); end
    repeat (2) @(negedge clk);
    pulse_start(8'h00);
    get_frame();
    vectors++; if (f_bits[9] !== ODD) begin miscompares++; $display("FAIL parity_00_bit: got %b want %b", f_bits[9], ODD); end
    vectors++; if (parity_o !== ODD) begin miscompares++; $display("FAIL parity_00_o: got %b want %b", parity_o, ODD); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    int extra_done, low_cnt;
    pulse_start(8'hA3);
    fork
      get_frame();
      begin
        repeat (30) @(negedge clk);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    vectors++; if (f_bits !== frame_of(8'hA3, 1'b0)) begin miscompares++; $display("FAIL ignore_bits: got %b want %b", f_bits, frame_of(8'hA3, 1'b0)); end
    vectors++; if (f_done_cnt != 1) begin miscompares++; $display("FAIL ignore_done_cnt: got %0d want 1", f_done_cnt); end
    extra_done = 0; low_cnt = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra_done++;
      if (tx !== 1'b1) low_cnt++;
    end
    vectors++; if (extra_done != 0) begin miscompares++; $display("FAIL ignore_extra_done: got %0d want 0", extra_done); end
    vectors++; if (low_cnt != 0) begin miscompares++; $display("FAIL ignore_second_frame: tx low %0d cycles want 0", low_cnt); end
  endtask

  task automatic test_back_to_back();
    int s1, idle_busy;
    tx_data  = 8'h31;
    tx_start = 1'b1;
    @(negedge clk);
    get_frame();
    s1 = f_start;
    vectors++; if (f_bits !== frame_of(8'h31, 1'b1)) begin miscompares++; $display("FAIL b2b_first_bits: got %b want %b", f_bits, frame_of(8'h31, 1'b1)); end
    vectors++; if (f_done_n != FRAME_CYC) begin miscompares++; $display("FAIL b2b_first_done_at: got %0d want %0d", f_done_n, FRAME_CYC); end
    tx_data = 8'h32;
    fork
      get_frame();
      begin
        repeat (2) @(negedge clk);
        tx_start = 1'b0;
      end
    join
    vectors++; if (!f_found) begin miscompares++; $display("FAIL b2b_second_found: no start bit within bound"); end
    vectors++; if (f_start - s1 != FRAME_CYC + 1) begin miscompares++; $display("FAIL b2b_gap: frame spacing %0d want %0d", f_start - s1, FRAME_CYC + 1); end
    vectors++; if (f_bits !== frame_of(8'h32, 1'b1)) begin miscompares++; $display("FAIL b2b_second_bits: got %b want %b", f_bits, frame_of(8'h32, 1'b1)); end
    vectors++; if (f_done_n != FRAME_CYC) begin miscompares++; $display("FAIL b2b_second_done_at: got %0d want %0d", f_done_n, FRAME_CYC); end
    idle_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) idle_busy++;
    end
    vectors++; if (idle_busy != 0) begin miscompares++; $display("FAIL b2b_third_frame: busy %0d cycles want 0", idle_busy); end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    pulse_start(8'h3C);
    repeat (4 * BC + BC / 2) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL midrst_tx: got %b want 1", tx); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy); end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (done !== 1'b0 || tx !== 1'b1) bad++;
      @(negedge clk);
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL midrst_after: %0d bad cycles want 0", bad); end
    pulse_start(8'h5A);
    get_frame();
    vectors++; if (f_bits !== frame_of(8'h5A, 1'b0)) begin miscompares++; $display("FAIL midrst_5a_bits: got %b want %b", f_bits, frame_of(8'h5A, 1'b0)); end
    vectors++; if (f_done_cnt != 1) begin miscompares++; $display("FAIL midrst_5a_done: got %0d want 1", f_done_cnt); end
    repeat (2) @(negedge clk);
  endtask

  // Receiver view of the line: reassemble data and parity from mid-bit samples.
  task automatic test_loopback();
    logic [7:0] rx_data;
    logic       rx_par;
    pulse_start(8'h48);
    get_frame();
    rx_data = f_bits[8:1];
    rx_par  = f_bits[9];
    vectors++; if (rx_data !== 8'h48) begin miscompares++; $display("FAIL loop_data: got %h want 48", rx_data); end
    vectors++; if (rx_par !== ODD) begin miscompares++; $display("FAIL loop_parity: got %b want %b", rx_par, ODD); end
    vectors++; if (f_bits[0] !== 1'b0 || f_bits[10] !== 1'b1) begin miscompares++; $display("FAIL loop_framing: start %b stop %b want 0 1", f_bits[0], f_bits[10]); end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_parity();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
